conv_result_streamer: RTL

- Downstream stage of the pipelined convolver.
- On the convolver's completion flag, it captures the flattened result vector (N_OUT signed 16-bit words).
- It then streams the words out one per transfer on a valid/ready interface, with optional arithmetic right-shift rescaling (round-half-up).
- It tracks completed frames and flags frames that arrive while it is still busy streaming.

---
 rtl/conv_result_streamer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/conv_result_streamer.sv
// Captures a convolver result frame and streams it word by word
// over valid/ready, with optional round-half-up right-shift rescaling.
module conv_result_streamer #(
    parameter int LEN             = 2,
    parameter int SIGNAL_LENGTH_1 = 4,
    parameter int SHIFT           = 0,
    parameter int IDX_W           = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    conv_done,
    input  logic [(LEN+SIGNAL_LENGTH_1+1)*16:0]     conv_result,
    input  logic                                    clear_ovr,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic [15:0]                             out_data,
    output logic [IDX_W-1:0]                        out_index,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    overrun,
    output logic [IDX_W-1:0]                        frame_count
);

    localparam int N_OUT = LEN + SIGNAL_LENGTH_1 + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_done_q;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_frame_cnt;
    logic                   r_ovr;
    logic [N_OUT*16-1:0]    r_buf;

    logic                   w_start;
    logic                   w_xfer;
    logic                   w_final;
    logic                   w_capture;
    logic                   w_streaming;
    logic [15:0]            w_head;
    logic [15:0]            w_scaled;
    logic                   w_unused;

    assign w_unused    = conv_result[N_OUT*16];
    assign w_streaming = (r_state == S_STREAM);
    assign w_start     = conv_done & ~r_done_q;
    assign w_xfer      = w_streaming & out_ready;
    assign w_final     = w_xfer & (r_idx == LAST);
    // A start on the final transfer is accepted as a back-to-back frame
    assign w_capture   = w_start & (~w_streaming | w_final);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_final && !w_start) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid   = w_streaming;
        busy        = w_streaming;
        out_data    = w_streaming ? w_scaled : 16'h0000;
        out_index   = w_streaming ? r_idx : '0;
        out_last    = w_streaming & (r_idx == LAST);
        overrun     = r_ovr;
        frame_count = r_frame_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q    <= 1'b0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_ovr       <= 1'b0;
        end else begin
            r_done_q <= conv_done;
            if (w_capture || w_final) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_final) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_start && w_streaming && !w_final) begin
                r_ovr <= 1'b1;
            end else if (clear_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Word buffer shifts down on each transfer; head is always the next word
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= conv_result[N_OUT*16-1:0];
        end else if (w_xfer) begin
            r_buf <= {16'h0000, r_buf[N_OUT*16-1:16]};
        end
    end

    assign w_head = r_buf[15:0];

    generate
        if (SHIFT == 0) begin : g_noshift
            assign w_scaled = w_head;
        end else begin : g_shift
            localparam logic signed [16:0] RND = 17'(1 << (SHIFT - 1));
            logic signed [16:0] w_sum;
            assign w_sum    = $signed({w_head[15], w_head}) + RND;
            assign w_scaled = 16'(w_sum >>> SHIFT);
        end
    endgenerate

endmodule
